// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//   CLK_PER_HALF_BIT_DEFAULT - default clk cycles per half bit period
//   uart_byte_t              - received data byte
//   rx_state_t / St*         - receive FSM state encoding
package uart_pkg;

  localparam int unsigned CLK_PER_HALF_BIT_DEFAULT = 86;

  typedef logic [7:0] uart_byte_t;

  typedef logic [1:0] rx_state_t;

  localparam rx_state_t StIdle  = 2'd0;
  localparam rx_state_t StStart = 2'd1;
  localparam rx_state_t StData  = 2'd2;
  localparam rx_state_t StStop  = 2'd3;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with extra-bit pointers for full/empty.
//   clk, rstn    - clock, asynchronous active-low reset
//   push, wdata  - write request and data
//   pop          - read request; rdata shows the head entry
//   full, empty  - occupancy flags
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wptr_q, wptr_d;
  logic [AddrW:0]   rptr_q, rptr_d;
  logic             wr_en, rd_en;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                 (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);

  assign rd_en = pop & ~empty;
  // When full, a simultaneous pop frees the head slot that the write reuses.
  assign wr_en = push & (~full | rd_en);

  assign rdata = mem_q[rptr_q[AddrW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_en) wptr_d = wptr_q + 1'b1;
    if (rd_en) rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q[AddrW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with a receive buffer.
//   clk, rstn - clock, asynchronous active-low reset
//   rxd       - asynchronous serial input, idle high, LSB first
//   rdata     - byte at buffer head; rvalid marks it valid
//   rready    - consumer accept; transfer when rvalid && rready
//   ferr      - one-cycle pulse on a low stop bit (byte discarded)
//   overrun   - one-cycle pulse when a good byte is dropped
// Macro UART_RX_FIFO_EN: defined -> FIFO_DEPTH-entry sync_fifo buffer;
// undefined -> single holding register, FIFO_DEPTH unused.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_HALF_BIT = CLK_PER_HALF_BIT_DEFAULT,
  parameter int unsigned FIFO_DEPTH       = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output uart_byte_t rdata,
  output logic       rvalid,
  input  logic       rready,
  output logic       ferr,
  output logic       overrun
);

  localparam int unsigned CntW = $clog2(2 * CLK_PER_HALF_BIT);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLK_PER_HALF_BIT - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(2 * CLK_PER_HALF_BIT - 1);

  logic [1:0]      sync_q;
  logic            rx_sync, rx_prev_q;
  rx_state_t       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  uart_byte_t      shift_q, shift_d;
  logic            push, frame_err, pop, drop;
  logic            ferr_q, overrun_q;

  assign rx_sync = sync_q[1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], rxd};
      rx_prev_q <= rx_sync;
    end
  end

  // Counter restarts from zero on every state change and after each data bit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        // Falling edge only; a line held low never retriggers.
        if (rx_prev_q && !rx_sync) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_sync ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          shift_d = {rx_sync, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          state_d = StIdle;
          if (rx_sync) push = 1'b1;
          else         frame_err = 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  assign pop = rvalid & rready;

`ifdef UART_RX_FIFO_EN
  logic       fifo_full, fifo_empty;
  uart_byte_t fifo_rdata;

  sync_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (8)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .wdata (shift_q),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rvalid = ~fifo_empty;
  // Storage is not reset; present zero whenever nothing is buffered.
  assign rdata  = fifo_empty ? '0 : fifo_rdata;
  assign drop   = push & fifo_full & ~pop;
`else
  uart_byte_t  hold_q;
  logic        hold_valid_q;
  logic [31:0] unused_fifo_depth;

  assign unused_fifo_depth = FIFO_DEPTH;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else if (push && (!hold_valid_q || pop)) begin
      hold_q       <= shift_q;
      hold_valid_q <= 1'b1;
    end else if (pop) begin
      hold_valid_q <= 1'b0;
    end
  end

  assign rvalid = hold_valid_q;
  assign rdata  = hold_q;
  assign drop   = push & hold_valid_q & ~pop;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      ferr_q    <= frame_err;
      overrun_q <= drop;
    end
  end

  assign ferr    = ferr_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int unsigned Half = 4;
`ifdef UART_RX_FIFO_EN
  localparam int Depth = 16;
`else
  localparam int Depth = 1;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rxd = 1'b1;
  logic       rready = 1'b0;
  logic [7:0] rdata;
  logic       rvalid, ferr, overrun;

  uart_rx_fifo #(
    .CLK_PER_HALF_BIT (Half),
    .FIFO_DEPTH       (16)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .rxd     (rxd),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .rready  (rready),
    .ferr    (ferr),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  logic [7:0] exp_byte;
  int ferr_cnt = 0, ovr_cnt = 0, valid_cycles = 0, last_rise = -1, last_len = 0;
  logic prev_valid = 1'b0, prev_hold = 1'b0;
  logic [7:0] prev_rdata = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every transfer is matched against the expected queue.
  always @(negedge clk) begin
    if (rvalid && !prev_valid) begin
      last_rise = cyc;
      last_len  = 0;
    end
    if (rvalid) begin
      last_len++;
      valid_cycles++;
    end
    if (ferr) ferr_cnt++;
    if (overrun) ovr_cnt++;
    if (prev_hold && rvalid) check("rdata_hold", {24'h0, rdata}, {24'h0, prev_rdata});
    if (rvalid && rready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte actual=%02h expected=none", rdata);
      end else begin
        exp_byte = exp_q.pop_front();
        check("rx_byte", {24'h0, rdata}, {24'h0, exp_byte});
      end
    end
    prev_valid = rvalid;
    prev_hold  = rvalid && !rready;
    prev_rdata = rdata;
  end

  // Drives one frame; abort_bit < 8 stops halfway into that data bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int abort_bit,
                            output int c0);
    @(posedge clk);
    #1 rxd = 1'b0;
    c0 = cyc;
    repeat (2 * Half) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rxd = b[i];
      if (i == abort_bit) begin
        repeat (Half) @(posedge clk);
        return;
      end
      repeat (2 * Half) @(posedge clk);
    end
    #1 rxd = stop;
    repeat (2 * Half) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (Half) @(posedge clk);
  endtask

  task automatic drain();
    #1 rready = 1'b1;
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("drain_left", exp_q.size(), 0);
    check("rvalid_after_drain", {31'h0, rvalid}, 0);
  endtask

  initial begin
    int c0, base_v, base_f, base_o;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rvalid", {31'h0, rvalid}, 0);
    check("reset_rdata", {24'h0, rdata}, 0);
    check("reset_ferr", {31'h0, ferr}, 0);
    check("reset_overrun", {31'h0, overrun}, 0);
    rstn = 1'b1;
    repeat (4) @(posedge clk);

    // Single byte, consumer always ready.
    #1 rready = 1'b1;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 8, c0);
    repeat (10) @(posedge clk);
    check("latency_0x55", last_rise, c0 + 79);
    check("width_0x55", last_len, 1);
    check("queue_0x55", exp_q.size(), 0);

    // Short low glitch: rejected in START, no flags.
    base_v = valid_cycles;
    base_f = ferr_cnt;
    @(posedge clk);
    #1 rxd = 1'b0;
    repeat (3) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (40) @(posedge clk);
    check("glitch_rvalid", valid_cycles - base_v, 0);
    check("glitch_ferr", ferr_cnt - base_f, 0);

    // Framing error, then a good frame.
    base_v = valid_cycles;
    base_f = ferr_cnt;
    send_frame(8'hA3, 1'b0, 8, c0);
    repeat (4) @(posedge clk);
    check("ferr_pulse", ferr_cnt - base_f, 1);
    check("ferr_no_rvalid", valid_cycles - base_v, 0);
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1, 8, c0);
    drain();

    // Fill with consumer stalled; overflow drops and pulses overrun.
    #1 rready = 1'b0;
    base_o = ovr_cnt;
    for (int v = 0; v < 17; v++) begin
      if (v < Depth) exp_q.push_back(v[7:0]);
      send_frame(v[7:0], 1'b1, 8, c0);
      check("overrun_count", ovr_cnt - base_o, (v + 1 > Depth) ? v + 1 - Depth : 0);
    end
    drain();

    // Reset mid data bit 4 abandons the frame.
    base_f = ferr_cnt;
    send_frame(8'h3C, 1'b1, 4, c0);
    #1;
    rstn = 1'b0;
    rxd  = 1'b1;
    #2;
    check("midreset_rvalid", {31'h0, rvalid}, 0);
    check("midreset_rdata", {24'h0, rdata}, 0);
    check("midreset_ferr", {31'h0, ferr}, 0);
    check("midreset_overrun", {31'h0, overrun}, 0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (20) @(posedge clk);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 8, c0);
    drain();
    check("midreset_no_ferr", ferr_cnt - base_f, 0);

    // Two bytes while stalled: head must stay the first byte.
    #1 rready = 1'b0;
    base_o = ovr_cnt;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 8, c0);
    if (Depth > 1) exp_q.push_back(8'h22);
    send_frame(8'h22, 1'b1, 8, c0);
    repeat (4) @(posedge clk);
    #1;
    check("hold_rdata", {24'h0, rdata}, 32'h11);
    check("hold_rvalid", {31'h0, rvalid}, 1);
    check("hold_overrun", ovr_cnt - base_o, (Depth == 1) ? 1 : 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
